// File: rtl/traffic_pkg.sv
// traffic_pkg: one-hot phase encodings shared by the sequencer and the lighting stage
package traffic_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    ST_RED    = 3'b001,
    ST_YELLOW = 3'b010,
    ST_GREEN  = 3'b100
  } state_e;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter that never wraps below zero
module phase_timer #(
  parameter int CNT_W = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  input  logic             freeze_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= RST_VAL;
    else if (load_i) cnt_q <= load_val_i;
    else if (en_i && !freeze_i && cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
  end
  assign cnt_o  = cnt_q;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/traffic_phase_fsm.sv
// traffic_phase_fsm: RED->GREEN->YELLOW sequencer with pedestrian shortening and emergency hold
module traffic_phase_fsm import traffic_pkg::*; #(
  parameter int RED_TICKS       = 5,
  parameter int GREEN_TICKS     = 8,
  parameter int YELLOW_TICKS    = 2,
  parameter int MIN_GREEN_TICKS = 3,
  parameter int CNT_W           = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_en,
  input  logic               ped_req,
  input  logic               emergency,
  output logic [STATE_W-1:0] current_state,
  output logic [CNT_W-1:0]   remaining,
  output logic               ped_ack
);
  localparam logic [CNT_W-1:0] RED_LD    = CNT_W'(RED_TICKS - 1);
  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_TICKS - 1);
  // GREEN may be cut once remaining has dropped to this value (minimum dwell served)
  localparam logic [CNT_W-1:0] PED_MAX   = CNT_W'(GREEN_TICKS - 1 - MIN_GREEN_TICKS);

  state_e           state_q, state_d;
  logic             ped_pending_q, ped_ack_q;
  logic             load, zero, legal, ped_set, enter_red;
  logic [CNT_W-1:0] load_val;

  always_comb begin
    legal     = state_q inside {ST_RED, ST_YELLOW, ST_GREEN};
    ped_set   = ped_req && (state_q == ST_GREEN || state_q == ST_YELLOW);
    state_d   = state_q;
    load      = 1'b0;
    load_val  = RED_LD;
    if (!legal) begin
      state_d = ST_RED;
      load    = 1'b1;
    end else if (state_q == ST_RED && tick_en && zero && !emergency) begin
      state_d  = ST_GREEN;
      load     = 1'b1;
      load_val = GREEN_LD;
    end else if (state_q == ST_GREEN && tick_en &&
                 (emergency || zero || (ped_pending_q && remaining <= PED_MAX))) begin
      state_d  = ST_YELLOW;
      load     = 1'b1;
      load_val = YELLOW_LD;
    end else if (state_q == ST_YELLOW && tick_en && zero) begin
      state_d = ST_RED;
      load    = 1'b1;
    end
    enter_red = state_d == ST_RED && state_q != ST_RED;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_RED;
      ped_pending_q <= 1'b0;
      ped_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ped_ack_q     <= enter_red && (ped_pending_q || ped_set);
      ped_pending_q <= !enter_red && (ped_pending_q || ped_set);
    end
  end

  phase_timer #(.CNT_W(CNT_W), .RST_VAL(RED_LD)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .load_val_i(load_val),
    .en_i      (tick_en),
    .freeze_i  (state_q == ST_RED && emergency),
    .cnt_o     (remaining),
    .zero_o    (zero)
  );

  assign current_state = state_q;
  assign ped_ack       = ped_ack_q;
endmodule
